// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU port, debug/loader port, memory side, status.
// slave is the arbiter's view; master is the requesters plus the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              gnt_dbg;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, gnt_dbg
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, gnt_dbg
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared fixed-latency LC-3 memory.
// One access at a time: IDLE -> ISSUE -> WAIT(MEM_LAT) -> DONE.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 3
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              gnt_dbg;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              any_req;
    logic              pick_dbg;
    logic              mem_en;
    logic              mem_we;
    logic              cpu_ready;
    logic              dbg_ready;

    assign any_req  = bus.cpu_req | bus.dbg_req;
    // On a tie, the port that did not own the last grant wins.
    assign pick_dbg = bus.dbg_req & (~bus.cpu_req | ~gnt_dbg);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        dbg_ready = 1'b0;
        unique case (state)
            IDLE:  if (any_req) state_nxt = ISSUE;
            ISSUE: begin
                state_nxt = WAIT;
                mem_en    = 1'b1;
                mem_we    = we_q;
            end
            WAIT:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:  begin
                state_nxt = IDLE;
                cpu_ready = ~gnt_dbg;
                dbg_ready = gnt_dbg;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_dbg     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= 4'd0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (any_req) begin
                    gnt_dbg <= pick_dbg;
                    we_q    <= pick_dbg ? bus.dbg_we    : bus.cpu_we;
                    addr_q  <= pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
                    wdata_q <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                end
                ISSUE: cnt <= LAT_M1;
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!we_q) begin
                        if (gnt_dbg) dbg_rdata_q <= bus.mem_rdata;
                        else         cpu_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_ready = cpu_ready;
    assign bus.dbg_ready = dbg_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.gnt_dbg   = gnt_dbg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: MEM_LAT=3 and MEM_LAT=1 instances,
// directed vector table, hand sequences and a randomized schedule model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) a ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(rst), .bus(a));
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(rst), .bus(b));

    // Memories: writes on mem_en&we, read data emerges MEM_LAT cycles later.
    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];
    logic [15:0] pipe_a [0:2];
    logic [15:0] pipe_b;

    always @(posedge clk) begin
        if (rst) begin
            mem_a[16'h3000] <= 16'h1234;
            mem_a[16'hFFFF] <= 16'h00FF;
            for (int i = 0; i < 8; i++) mem_a[16'h0010 + 16'(i)] <= 16'hA000 + 16'(i);
        end else if (a.mem_en && a.mem_we) begin
            mem_a[a.mem_addr] <= a.mem_wdata;
        end
        pipe_a[0] <= (a.mem_en && !a.mem_we) ? mem_a[a.mem_addr] : 16'hBAD0;
        pipe_a[1] <= pipe_a[0];
        pipe_a[2] <= pipe_a[1];
    end
    assign a.mem_rdata = pipe_a[2];

    always @(posedge clk) begin
        if (rst) begin
            mem_b[16'h3000] <= 16'h1234;
            mem_b[16'hFFFF] <= 16'h00FF;
            for (int i = 0; i < 8; i++) mem_b[16'h0010 + 16'(i)] <= 16'hA000 + 16'(i);
        end else if (b.mem_en && b.mem_we) begin
            mem_b[b.mem_addr] <= b.mem_wdata;
        end
        pipe_b <= (b.mem_en && !b.mem_we) ? mem_b[b.mem_addr] : 16'hBAD1;
    end
    assign b.mem_rdata = pipe_b;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic drive(input logic d1, input logic port, input logic req, input logic we,
                         input logic [15:0] addr, input logic [15:0] wd);
        if (d1) begin
            if (port) begin b.dbg_req = req; b.dbg_we = we; b.dbg_addr = addr; b.dbg_wdata = wd; end
            else      begin b.cpu_req = req; b.cpu_we = we; b.cpu_addr = addr; b.cpu_wdata = wd; end
        end else begin
            if (port) begin a.dbg_req = req; a.dbg_we = we; a.dbg_addr = addr; a.dbg_wdata = wd; end
            else      begin a.cpu_req = req; a.cpu_we = we; a.cpu_addr = addr; a.cpu_wdata = wd; end
        end
    endtask

    task automatic do_reset();
        for (int p = 0; p < 2; p++) begin
            drive(1'b0, p[0], 1'b0, 1'b0, 16'h0, 16'h0);
            drive(1'b1, p[0], 1'b0, 1'b0, 16'h0, 16'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        check({tag, "_ctl_lat3"}, 64'({a.cpu_ready, a.dbg_ready, a.mem_en, a.mem_we, a.busy, a.gnt_dbg}), 64'd1);
        check({tag, "_data_lat3"}, {a.mem_addr, a.mem_wdata, a.cpu_rdata, a.dbg_rdata}, 64'd0);
        check({tag, "_ctl_lat1"}, 64'({b.cpu_ready, b.dbg_ready, b.mem_en, b.mem_we, b.busy, b.gnt_dbg}), 64'd1);
        check({tag, "_data_lat1"}, {b.mem_addr, b.mem_wdata, b.cpu_rdata, b.dbg_rdata}, 64'd0);
    endtask

    // One access; scr rewrites the port's inputs right after the grant.
    task automatic acc(input logic d1, input logic port, input logic we, input logic scr,
                       input logic [15:0] addr, input logic [15:0] wd,
                       output int lat, output logic [1:0] rdy, output logic ok,
                       output logic [15:0] rd);
        logic en, mw, bz;
        logic [15:0] ma, mwd;
        logic [1:0] r;
        repeat (2) @(negedge clk);
        drive(d1, port, 1'b1, we, addr, wd);
        lat = -1; rdy = 2'b00; ok = 1'b1; rd = 16'h0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1 && scr) drive(d1, port, 1'b1, ~we, 16'hFFFF, ~wd);
            en  = d1 ? b.mem_en    : a.mem_en;
            mw  = d1 ? b.mem_we    : a.mem_we;
            bz  = d1 ? b.busy      : a.busy;
            ma  = d1 ? b.mem_addr  : a.mem_addr;
            mwd = d1 ? b.mem_wdata : a.mem_wdata;
            r   = d1 ? {b.dbg_ready, b.cpu_ready} : {a.dbg_ready, a.cpu_ready};
            if (n == 1 && !en) ok = 1'b0;
            if (en && (n != 1 || mw != we || ma != addr || (we && mwd != wd))) ok = 1'b0;
            if (!bz || ma != addr) ok = 1'b0;
            if (r != 2'b00) begin
                lat = n;
                rdy = r;
                rd  = port ? (d1 ? b.dbg_rdata : a.dbg_rdata)
                           : (d1 ? b.cpu_rdata : a.cpu_rdata);
                break;
            end
        end
        drive(d1, port, 1'b0, we, addr, wd);
    endtask

    int   rt [4];
    logic rw [4];

    // Both ports on the LAT=3 unit re-request as soon as the protocol allows.
    task automatic race3(input int n);
        int k;
        bit hc, hd;
        k = 0; hc = 0; hd = 0;
        for (int i = 0; i < 4; i++) begin rt[i] = -1; rw[i] = 1'b0; end
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0);
        for (int c = 1; c <= 60 && k < n; c++) begin
            @(negedge clk);
            if (hc) hc = 0; else a.cpu_req = 1'b1;
            if (hd) hd = 0; else a.dbg_req = 1'b1;
            if (a.cpu_ready && k < 4) begin rt[k] = c; rw[k] = 1'b0; k++; a.cpu_req = 1'b0; hc = 1; end
            if (a.dbg_ready && k < 4) begin rt[k] = c; rw[k] = 1'b1; k++; a.dbg_req = 1'b0; hd = 1; end
        end
        a.cpu_req = 1'b0;
        a.dbg_req = 1'b0;
    endtask

    typedef struct {
        logic        d1;
        logic        port;
        logic        we;
        logic        scr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int lat;
        logic [1:0] rdy;
        logic ok, seen;
        logic [15:0] rd;
        int free, g;
        logic own, gwe;
        logic [15:0] gaddr, gwd, gexp;
        logic [15:0] shadow [8];
        logic [15:0] last_rd [2];
        logic rq [2], rwe [2];
        logic [15:0] radd [2], rwd [2];
        int hold [2];
        logic rn;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 5};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, 16'hBEEF, 16'h0000, 5};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'hBEEF, 5};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 5};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5A5A, 16'hBEEF, 5};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 5};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF, 5};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h0001, 16'h00FF, 5};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'h0001, 5};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'h1234, 3};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hCAFE, 16'h0000, 3};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hCAFE, 3};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF, 3};

        do_reset();
        chk_rst("reset");

        foreach (tbl[i]) begin
            acc(tbl[i].d1, tbl[i].port, tbl[i].we, tbl[i].scr, tbl[i].addr, tbl[i].wdata,
                lat, rdy, ok, rd);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            check($sformatf("vec%0d_ready", i), 64'(rdy), tbl[i].port ? 64'd2 : 64'd1);
            check($sformatf("vec%0d_mem_bus", i), 64'(ok), 64'd1);
            check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(tbl[i].exp));
        end

        // Last LAT=3 grant went to the CPU, so a tie now favours dbg.
        race3(2);
        check("tie_first", {32'(rt[0]), 31'd0, rw[0]}, {32'd5, 32'd1});
        check("tie_second", {32'(rt[1]), 31'd0, rw[1]}, {32'd11, 32'd0});

        do_reset();
        race3(4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), {32'(rt[i]), 31'd0, rw[i]},
                  {32'(5 + 6 * i), 31'd0, i[0]});

        // Reset in the middle of a CPU read.
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h0);
        seen = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (a.cpu_ready || a.dbg_ready) seen = 1'b1;
        end
        rst = 1'b1;
        a.cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (a.cpu_ready || a.dbg_ready) seen = 1'b1;
        end
        chk_rst("mid_reset");
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a.cpu_ready || a.dbg_ready) seen = 1'b1;
        end
        check("mid_reset_no_ready", 64'(seen), 64'd0);
        acc(1'b0, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0, lat, rdy, ok, rd);
        check("post_reset_read", {32'(lat), 14'd0, rdy, rd}, {32'd5, 14'd0, 2'b01, 16'h1234});

        // Randomized traffic against a schedule model of the LAT=3 unit.
        do_reset();
        for (int i = 0; i < 8; i++) shadow[i] = 16'hA000 + 16'(i);
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;
        free = 0; g = -100; own = 1'b1;
        gwe = 1'b0; gaddr = 16'h0; gwd = 16'h0; gexp = 16'h0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rwe[p] = 1'b0; radd[p] = 16'h0; rwd[p] = 16'h0; hold[p] = 0;
        end
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            rn = (t == g + 5);
            check("rand_ctl", 64'({a.cpu_ready, a.dbg_ready, a.mem_en, a.busy, a.gnt_dbg}),
                  64'({rn && !own, rn && own, t == g + 1, t < free, own}));
            if (t == g + 1)
                check("rand_mem_bus", {31'd0, a.mem_we, a.mem_addr, gwe ? a.mem_wdata : 16'h0},
                      {31'd0, gwe, gaddr, gwe ? gwd : 16'h0});
            if (rn) begin
                if (!gwe) last_rd[own] = gexp;
                check("rand_rdata", {32'h0, a.cpu_rdata, a.dbg_rdata},
                      {32'h0, last_rd[0], last_rd[1]});
                rq[own] = 1'b0;
                hold[own] = 2;
            end
            for (int p = 0; p < 2; p++) begin
                if (hold[p] > 0) hold[p]--;
                else if (!rq[p] && $urandom_range(2) == 0) begin
                    rq[p]   = 1'b1;
                    rwe[p]  = 1'($urandom_range(1));
                    radd[p] = 16'h0010 + 16'($urandom_range(7));
                    rwd[p]  = 16'($urandom);
                end
                drive(1'b0, p[0], rq[p], rwe[p], radd[p], rwd[p]);
            end
            if (t >= free && (rq[0] || rq[1])) begin
                own   = rq[1] && (!rq[0] || !own);
                g     = t;
                free  = t + 6;
                gwe   = rwe[own];
                gaddr = radd[own];
                gwd   = rwd[own];
                if (gwe) shadow[gaddr[2:0]] = gwd;
                else     gexp = shadow[gaddr[2:0]];
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
